a_lock_ctrl: RTL

//  Parametrised successor to the single-attempt password checker and error processor.

---
 rtl/a_lock_pkg.sv | 19 +
 rtl/a_lock_timer.sv | 35 +++
 rtl/a_lock_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/a_lock_pkg.sv
// Shared types and elaboration-time legality helpers for the keypad lock controller.
package a_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_t;

  function automatic bit max_err_legal(input int max_err, input int err_w);
    return (max_err >= 1) && (longint'(max_err) <= ((longint'(1) << err_w) - 1));
  endfunction

  // The timer is loaded with CYC-1, so CYC itself may equal 2**TMR_W.
  function automatic bit cyc_legal(input int cyc, input int tmr_w);
    return (cyc >= 1) && (longint'(cyc) <= (longint'(1) << tmr_w));
  endfunction

endpackage

// File: rtl/a_lock_timer.sv
// Loadable down-counter shared by the OPEN hold time and the LOCKOUT duration.
module a_lock_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic [TMR_W-1:0] count_o,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an enable left high never wraps the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/a_lock_ctrl.sv
// Password check, consecutive-failure lockout and timed auto-relock for the door lock.
// state   | meaning
// IDLE    | locked, waiting for an entry strobe
// OPEN    | lock released, hold timer running
// LOCKOUT | too many failures, keypad ignored until timeout or admin clear
module a_lock_ctrl
  import a_lock_pkg::*;
#(
  parameter int PW_W     = 16,
  parameter int ERR_W    = 3,
  parameter int MAX_ERR  = 5,
  parameter int TMR_W    = 16,
  parameter int LOCK_CYC = 1000,
  parameter int OPEN_CYC = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PW_W-1:0]  pw_in,
  input  logic [PW_W-1:0]  password,
  input  logic             enough,
  input  logic             rst_out,
  input  logic             relock,
  output logic             enb_lock,
  output logic             gen_stop,
  output logic             gen_rst,
  output logic [ERR_W-1:0] error_counter,
  output logic [TMR_W-1:0] lock_timer
);

  localparam bit MAX_ERR_OK  = max_err_legal(MAX_ERR, ERR_W);
  localparam bit LOCK_CYC_OK = cyc_legal(LOCK_CYC, TMR_W);
  localparam bit OPEN_CYC_OK = cyc_legal(OPEN_CYC, TMR_W);

  if (!MAX_ERR_OK) begin : g_bad_max_err
    $error("a_lock_ctrl: MAX_ERR must be in 1..2**ERR_W-1");
  end
  if (!LOCK_CYC_OK) begin : g_bad_lock_cyc
    $error("a_lock_ctrl: LOCK_CYC must be in 1..2**TMR_W");
  end
  if (!OPEN_CYC_OK) begin : g_bad_open_cyc
    $error("a_lock_ctrl: OPEN_CYC must be in 1..2**TMR_W");
  end

  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYC - 1);
  localparam logic [ERR_W:0]   MAX_ERR_X = (ERR_W+1)'(MAX_ERR);

  lock_state_t      state_q;
  logic             enb_lock_q, gen_stop_q, gen_rst_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             tmr_load_d, tmr_en_d, tmr_zero;
  logic [TMR_W-1:0] tmr_val_d, tmr_count;
  logic             pw_match, last_err, attempt;
  logic [ERR_W:0]   err_inc;

  assign pw_match = (pw_in == password);
  // One extra bit so the +1 can never wrap before the MAX_ERR compare.
  assign err_inc  = {1'b0, err_cnt_q} + 1'b1;
  assign last_err = (err_inc >= MAX_ERR_X);
  assign attempt  = enough && !rst_out;

  // Leaving OPEN/LOCKOUT reloads zero so lock_timer reads 0 throughout IDLE.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_en_d   = 1'b0;
    tmr_val_d  = '0;
    case (state_q)
      IDLE: begin
        if (attempt && pw_match) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = OPEN_LOAD;
        end else if (attempt && last_err) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = LOCK_LOAD;
        end
      end
      OPEN: begin
        if (relock || tmr_zero) tmr_load_d = 1'b1;
        else                    tmr_en_d   = 1'b1;
      end
      LOCKOUT: begin
        if (tmr_zero || rst_out) tmr_load_d = 1'b1;
        else                     tmr_en_d   = 1'b1;
      end
      default: tmr_load_d = 1'b1;
    endcase
  end

  a_lock_timer #(.TMR_W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_d),
    .en_i       (tmr_en_d),
    .load_val_i (tmr_val_d),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      enb_lock_q <= 1'b0;
      gen_stop_q <= 1'b0;
      gen_rst_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      gen_rst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rst_out) begin
            err_cnt_q <= '0;
          end else if (enough) begin
            gen_rst_q <= 1'b1;
            if (pw_match) begin
              state_q    <= OPEN;
              enb_lock_q <= 1'b1;
              err_cnt_q  <= '0;
            end else if (last_err) begin
              state_q    <= LOCKOUT;
              gen_stop_q <= 1'b1;
              err_cnt_q  <= ERR_W'(MAX_ERR);
            end else begin
              err_cnt_q <= err_inc[ERR_W-1:0];
            end
          end
        end
        OPEN: begin
          if (relock || tmr_zero) begin
            state_q    <= IDLE;
            enb_lock_q <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (tmr_zero || rst_out) begin
            state_q    <= IDLE;
            gen_stop_q <= 1'b0;
            err_cnt_q  <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          enb_lock_q <= 1'b0;
          gen_stop_q <= 1'b0;
          err_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign enb_lock      = enb_lock_q;
  assign gen_stop      = gen_stop_q;
  assign gen_rst       = gen_rst_q;
  assign error_counter = err_cnt_q;
  assign lock_timer    = tmr_count;

endmodule
